// File: rtl/lm35_temp_readout.sv
`default_nettype none
// ============================================================================
//  Module   : lm35_temp_readout
//  Purpose  : Periodically reads the LM35DM board-temperature sensor through
//             an external 12-bit serial ADC (CS_N/SCLK/SDO, read-only,
//             MSB-first), averages 2**AVG_LOG2 samples, publishes the average
//             with a one-cycle valid strobe and drives a hysteretic
//             over-temperature flag.
//  Ports    : clk_i          system clock, rising edge
//             rst_ni         asynchronous active-low reset
//             enable_i       run periodic conversions (sampled at frame start)
//             adc_sdo_i      ADC serial data
//             adc_cs_n_o     ADC chip select, active low
//             adc_sclk_o     ADC serial clock, idles low
//             temp_data_o    last averaged ADC code
//             temp_valid_o   one-cycle pulse when temp_data_o updates
//             over_temp_o    hysteretic over-temperature flag
//             busy_o         high while adc_cs_n_o is low
//  Revision : 1.0  initial release
// ============================================================================
module lm35_temp_readout #(
  parameter int          SCLK_DIV      = 4,
  parameter int          SAMPLE_PERIOD = 50000,
  parameter int          AVG_LOG2      = 3,
  parameter logic [11:0] ALARM_HI      = 12'h3E8,
  parameter logic [11:0] ALARM_LO      = 12'h3C0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        adc_sdo_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [11:0] temp_data_o,
  output logic        temp_valid_o,
  output logic        over_temp_o,
  output logic        busy_o
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   per_q,   per_d;
  logic [DW-1:0]   div_q,   div_d;
  logic [3:0]      bit_q,   bit_d;
  logic            sclk_q,  sclk_d;
  logic            cs_n_q,  cs_n_d;
  // Only the low 12 bits of the 16-bit frame are kept; the four leading
  // bits shift out of the top and are never looked at.
  logic [11:0]     shift_q, shift_d;
  logic [AW-1:0]   acc_q,   acc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [11:0]     data_q,  data_d;
  logic            valid_q, valid_d;
  logic            over_q,  over_d;

  logic            frame_start;
  logic [AW-1:0]   sum;

  assign frame_start = (per_q == PER_LAST);
  // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples.
  assign sum         = acc_q + AW'(shift_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = frame_start ? '0 : per_q + 1'b1;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    over_d  = over_q;

    case (state_q)
      IDLE: begin
        if (frame_start && enable_i) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            // SDO is captured on the same clock that raises SCLK, i.e. the
            // value the ADC has held through the whole low phase.
            sclk_d  = 1'b1;
            shift_d = {shift_q[10:0], adc_sdo_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      HOLD: begin
        // CS_N is released on leaving HOLD, so the low window covers the
        // whole frame including this cycle.
        cs_n_d  = 1'b1;
        state_d = IDLE;
        if (cnt_q == CNT_LAST) begin
          data_d  = sum[AW-1:AVG_LOG2];
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Alarm looks at the freshly published average only.
    if (valid_q) begin
      if (data_q >= ALARM_HI) begin
        over_d = 1'b1;
      end else if (data_q < ALARM_LO) begin
        over_d = 1'b0;
      end
    end
  end

  assign adc_cs_n_o   = cs_n_q;
  assign adc_sclk_o   = sclk_q;
  assign temp_data_o  = data_q;
  assign temp_valid_o = valid_q;
  assign over_temp_o  = over_q;
  assign busy_o       = ~cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_lm35_temp_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lm35_temp_readout
//  Purpose  : Directed self-checking bench for lm35_temp_readout with a
//             behavioural serial-ADC model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lm35_temp_readout;

  localparam int PERIOD = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        adc_sdo;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] temp_data;
  logic        temp_valid;
  logic        over_temp;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // ADC model / monitor state
  logic [11:0] next_sample = 12'h000;
  logic [15:0] adc_word    = 16'h0000;
  logic        prev_cs     = 1'b1;
  logic        prev_sclk   = 1'b0;
  logic        prev_valid  = 1'b0;
  int          cyc         = 0;
  int          cs_falls    = 0;
  int          cs_rises    = 0;
  int          valid_cnt   = 0;
  int          rises_frame = 0;
  int          last_frame_rises = 0;

  lm35_temp_readout #(
    .SCLK_DIV      (4),
    .SAMPLE_PERIOD (PERIOD),
    .AVG_LOG2      (3),
    .ALARM_HI      (12'h3E8),
    .ALARM_LO      (12'h3C0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .adc_sdo_i    (adc_sdo),
    .adc_cs_n_o   (adc_cs_n),
    .adc_sclk_o   (adc_sclk),
    .temp_data_o  (temp_data),
    .temp_valid_o (temp_valid),
    .over_temp_o  (over_temp),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // ADC returns {4'hA, next_sample}; the leading nibble must be ignored.
  assign adc_sdo = adc_word[15];

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !adc_cs_n) begin
      adc_word    = {4'hA, next_sample};
      cs_falls++;
      rises_frame = 0;
    end else if (prev_sclk && !adc_sclk) begin
      adc_word = {adc_word[14:0], 1'b0};
    end
    if (!prev_sclk && adc_sclk) rises_frame++;
    if (!prev_cs && adc_cs_n) begin
      cs_rises++;
      last_frame_rises = rises_frame;
    end
    if (temp_valid && !prev_valid) valid_cnt++;
    prev_cs    = adc_cs_n;
    prev_sclk  = adc_sclk;
    prev_valid = temp_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int k = 0;
    while (adc_cs_n !== lvl && k < 2 * PERIOD) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 32'(adc_cs_n === lvl), 32'd1);
  endtask

  task automatic wait_cs_rises(input int n, input string tag);
    int start = cs_rises;
    int k = 0;
    while (cs_rises < start + n && k < (n + 2) * PERIOD) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 32'(cs_rises >= start + n), 32'd1);
  endtask

  task automatic wait_valid(input int frames, input string tag);
    int start = valid_cnt;
    int k = 0;
    while (valid_cnt == start && k < (frames + 2) * PERIOD) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 32'(valid_cnt != start), 32'd1);
  endtask

  // Runs one full averaging block of constant samples and checks the result.
  task automatic do_block(input logic [11:0] v, input logic exp_over, input string tag);
    next_sample = v;
    wait_valid(8, tag);
    check({tag, "_data"}, 32'(temp_data), 32'(v));
    step();
    check({tag, "_over"}, 32'(over_temp), 32'(exp_over));
  endtask

  initial begin
    int t0, low, rises, run, bad_hi, bad_lo, bad_busy, falls0, valid0;
    logic ps;

    rst_n       = 1'b0;
    enable      = 1'b1;
    next_sample = 12'h200;
    repeat (3) step();

    // Reset state
    check("rst_cs_n",  32'(adc_cs_n),   32'd1);
    check("rst_sclk",  32'(adc_sclk),   32'd0);
    check("rst_data",  32'(temp_data),  32'd0);
    check("rst_valid", 32'(temp_valid), 32'd0);
    check("rst_over",  32'(over_temp),  32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;

    // SCLK / CS timing on the first frame
    wait_cs(1'b0, "first_frame");
    t0 = cyc; low = 0; rises = 0; run = 0; bad_hi = 0; bad_lo = 0; bad_busy = 0; ps = 1'b0;
    while (adc_cs_n == 1'b0 && low < 1000) begin
      low++;
      if (busy !== ~adc_cs_n) bad_busy++;
      if (adc_sclk != ps) begin
        if (adc_sclk) begin
          rises++;
          if (rises > 1 && run != 4) bad_lo++;
        end else if (run != 4) begin
          bad_hi++;
        end
        run = 1;
      end else begin
        run++;
      end
      ps = adc_sclk;
      step();
    end
    check("cs_low_len",   32'(low),      32'd133);
    check("sclk_rises",   32'(rises),    32'd16);
    check("sclk_high_4",  32'(bad_hi),   32'd0);
    check("sclk_low_4",   32'(bad_lo),   32'd0);
    check("busy_tracks",  32'(bad_busy), 32'd0);
    check("sclk_idle",    32'(adc_sclk), 32'd0);
    wait_cs(1'b0, "second_frame");
    check("frame_period", 32'(cyc - t0), 32'(PERIOD));

    // Basic averaging: 8 frames of 0x200
    wait_valid(8, "avg1");
    check("avg1_frames", 32'(cs_falls),  32'd8);
    check("avg1_data",   32'(temp_data), 32'h200);
    step();
    check("valid_width", 32'(temp_valid), 32'd0);
    check("avg1_over",   32'(over_temp),  32'd0);

    // Truncation: 7 x 0x001 + 1 x 0x002 -> 9/8 -> 0x001
    next_sample = 12'h001;
    wait_cs_rises(7, "trunc7");
    next_sample = 12'h002;
    wait_valid(2, "trunc");
    check("trunc_data", 32'(temp_data), 32'h001);

    // Alarm hysteresis
    do_block(12'h3E8, 1'b1, "alarm_3e8");
    do_block(12'h3D0, 1'b1, "alarm_3d0");
    do_block(12'h3BF, 1'b0, "alarm_3bf");

    // ENABLE drop during the 3rd sample; 3 x 0x100 then 5 x 0x200 -> 0x1A0
    next_sample = 12'h100;
    wait_cs_rises(2, "en_pre");
    wait_cs(1'b0, "en_third");
    repeat (30) step();
    check("en_mid_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_cs(1'b1, "en_finish");
    check("en_frame_rises", 32'(last_frame_rises), 32'd16);
    next_sample = 12'h200;
    falls0 = cs_falls;
    valid0 = valid_cnt;
    repeat (2 * PERIOD) step();
    check("en_off_frames", 32'(cs_falls - falls0),  32'd0);
    check("en_off_valid",  32'(valid_cnt - valid0), 32'd0);
    enable = 1'b1;
    wait_valid(6, "en_resume");
    check("en_resume_frames", 32'(cs_falls - falls0), 32'd5);
    check("en_resume_data",   32'(temp_data),         32'h1A0);

    // Reset mid-SHIFT, with the alarm set beforehand
    do_block(12'h3E8, 1'b1, "pre_rst");
    wait_cs_rises(3, "rst_partial");
    wait_cs(1'b0, "rst_frame");
    repeat (20) step();
    run = 0;
    while (adc_sclk !== 1'b1 && run < 20) begin
      step();
      run++;
    end
    check("rst_sclk_high", 32'(adc_sclk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n",  32'(adc_cs_n),   32'd1);
    check("mid_rst_sclk",  32'(adc_sclk),   32'd0);
    check("mid_rst_busy",  32'(busy),       32'd0);
    check("mid_rst_data",  32'(temp_data),  32'd0);
    check("mid_rst_valid", 32'(temp_valid), 32'd0);
    check("mid_rst_over",  32'(over_temp),  32'd0);
    repeat (2) step();
    next_sample = 12'h3E7;
    falls0 = cs_falls;
    rst_n = 1'b1;
    wait_valid(9, "post_rst");
    check("post_rst_frames", 32'(cs_falls - falls0), 32'd8);
    check("post_rst_data",   32'(temp_data),         32'h3E7);
    step();
    check("post_rst_over",   32'(over_temp),         32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
